fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The module SHALL have the parameter RESET_PC, default 32'h0000_0000, which is the first fetch address after reset.
REQ-002 clk  in  1  the single clock; all state is updated on its rising edge.
REQ-003 srst  in  1  synchronous, active-high reset.
REQ-004 stall_f  in  1  from the hazard unit; blocks issue of a new request.
REQ-005 stall_d  in  1  from the hazard unit; holds the IF/ID register.
REQ-006 flush_d  in  1  from the hazard unit; loads a bubble into IF/ID.
REQ-007 pc_src_e  in  1  redirect request from the execute stage.
REQ-008 pc_target_e  in  32  redirect address.
REQ-009 imem_req  out  1  one-cycle instruction-memory request pulse.
REQ-010 imem_addr  out  32  request address, valid while imem_req=1.
REQ-011 imem_rvalid  in  1  response strobe; latency of 1 or more cycles; at most one request is outstanding.
REQ-012 imem_rdata  in  32  instruction word, valid with imem_rvalid.
REQ-013 instr_d / pc_d / pc_plus4_d  out  32 each  IF/ID register contents.
REQ-014 valid_d  out  1  IF/ID holds a real instruction, not a bubble.

Function
REQ-015 The FSM SHALL have the states ISSUE, WAIT, HOLD and DROP.
REQ-016 ISSUE: imem_req=1 and imem_addr=pc_f only when !stall_f && !pc_src_e; the FSM then goes to WAIT.
REQ-017 ISSUE with stall_f=1: no request is issued and the FSM stays in ISSUE.
REQ-018 pc_src_e=1 in ISSUE: pc_f<=pc_target_e, no request is issued, and the FSM stays in ISSUE.
REQ-019 WAIT, rvalid=1, stall_d=0, pc_src_e=0: deliver to IF/ID (instr_d<=rdata, pc_d<=pc_f, pc_plus4_d<=pc_f+4, valid_d<=1), set pc_f<=pc_f+4, go to ISSUE.
REQ-020 WAIT, rvalid=1, stall_d=1, pc_src_e=0: capture rdata and pc_f into the hold buffer and go to HOLD.
REQ-021 WAIT, pc_src_e=1, rvalid=0: pc_f<=pc_target_e and go to DROP.
REQ-022 WAIT, pc_src_e=1 and rvalid=1 in the same cycle: discard the response, pc_f<=pc_target_e, go to ISSUE.
REQ-023 DROP: ignore pc_src_e-free cycles; on rvalid, discard the response and go to ISSUE.
REQ-024 DROP with pc_src_e=1: pc_f<=pc_target_e and the FSM stays in DROP.
REQ-025 HOLD with stall_d=0: deliver the held word as in REQ-019 and go to ISSUE.
REQ-026 HOLD with pc_src_e=1: discard the buffer, pc_f<=pc_target_e, go to ISSUE.
REQ-027 IF/ID update priority SHALL be: srst > flush_d > stall_d > delivery > bubble.
REQ-028 A bubble SHALL be: instr_d=NOP_INSTR (32'h0000_0013), pc_d=0, pc_plus4_d=0, valid_d=0.
REQ-029 Any cycle with !stall_d and no delivery SHALL load a bubble.
REQ-030 flush_d coinciding with a delivery SHALL discard the delivered word; pc_f still advances.
REQ-031 All PC arithmetic SHALL be 32-bit modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
REQ-032 Best-case throughput SHALL be one instruction per 2 cycles with 1-cycle memory latency (ISSUE then WAIT).

Reset
REQ-033 srst SHALL set pc_f=RESET_PC, state=ISSUE, hold buffer=0, IF/ID=bubble, imem_req=0 during the reset cycle.
REQ-034 srst asserted mid-WAIT SHALL abandon the request; a late rvalid arriving in ISSUE is ignored.

Structure
REQ-035 The shared package riscv_pkg SHALL hold NOP_INSTR, the default RESET_PC, and the fetch_state_t enum.
REQ-036 No sub-module is required; the hold buffer is inline registers.

Verification
REQ-037 Reset, then 1-cycle memory returning 0x00500093: imem_addr=0x0 then 0x4; instr_d=0x00500093, pc_d=0, pc_plus4_d=4, valid_d=1.
REQ-038 Response arriving while stall_d=1 for 3 cycles: IF/ID holds its old value, the FSM is in HOLD, and the word is delivered on the cycle after stall_d falls with pc_d unchanged.
REQ-039 pc_src_e=1 with pc_target_e=0x100 in WAIT, with a 3-cycle latency: the stale response is discarded, the next imem_addr=0x100, and bubbles are loaded meanwhile.
REQ-040 pc_src_e and rvalid in the same cycle: no delivery, and the next request goes to pc_target_e.
REQ-041 flush_d pulse during a delivery: instr_d=0x00000013 and valid_d=0; the following fetch is at pc+4.
REQ-042 RESET_PC=0xFFFF_FFFC: the second imem_addr=0x0000_0000.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-fetch front end.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } fetch_state_t;

    // Sequential next-PC; wraps modulo 2^32 by construction.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one memory request at a time, parks a
// response that arrives while decode is stalled, and kills responses made
// stale by an execute-stage redirect. Output is the IF/ID pipeline register.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        srst,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        pc_src_e,
    input  logic [31:0] pc_target_e,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_f_q, pc_f_d;
    logic [31:0]  hold_instr_q, hold_instr_d;
    logic [31:0]  hold_pc_q, hold_pc_d;
    logic [31:0]  ifid_instr_q, ifid_instr_d;
    logic [31:0]  ifid_pc_q, ifid_pc_d;
    logic [31:0]  ifid_pc4_q, ifid_pc4_d;
    logic         ifid_valid_q, ifid_valid_d;

    logic         req;
    logic         deliver;
    logic [31:0]  dlv_instr;
    logic [31:0]  dlv_pc;

    // Next-state, PC and hold-buffer logic; decides whether a word reaches decode.
    always_comb begin
        state_d      = state_q;
        pc_f_d       = pc_f_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        req          = 1'b0;
        deliver      = 1'b0;
        dlv_instr    = hold_instr_q;
        dlv_pc       = hold_pc_q;

        unique case (state_q)
            ISSUE: begin
                if (pc_src_e) begin
                    pc_f_d = pc_target_e;
                end else if (!stall_f) begin
                    req     = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (pc_src_e) begin
                        // Response belongs to the wrong path: drop it on the floor.
                        pc_f_d  = pc_target_e;
                        state_d = ISSUE;
                    end else if (stall_d) begin
                        hold_instr_d = imem_rdata;
                        hold_pc_d    = pc_f_q;
                        state_d      = HOLD;
                    end else begin
                        deliver   = 1'b1;
                        dlv_instr = imem_rdata;
                        dlv_pc    = pc_f_q;
                        pc_f_d    = pc_plus4(pc_f_q);
                        state_d   = ISSUE;
                    end
                end else if (pc_src_e) begin
                    // Request still in flight; its response must be swallowed.
                    pc_f_d  = pc_target_e;
                    state_d = DROP;
                end
            end
            HOLD: begin
                if (pc_src_e) begin
                    pc_f_d  = pc_target_e;
                    state_d = ISSUE;
                end else if (!stall_d) begin
                    deliver = 1'b1;
                    pc_f_d  = pc_plus4(pc_f_q);
                    state_d = ISSUE;
                end
            end
            DROP: begin
                if (pc_src_e) begin
                    pc_f_d = pc_target_e;
                end
                // No request remains outstanding once the stale response lands.
                if (imem_rvalid) begin
                    state_d = ISSUE;
                end
            end
            default: state_d = ISSUE;
        endcase
    end

    // IF/ID register next value: flush beats stall beats delivery beats bubble.
    always_comb begin
        ifid_instr_d = NOP_INSTR;
        ifid_pc_d    = 32'd0;
        ifid_pc4_d   = 32'd0;
        ifid_valid_d = 1'b0;
        if (flush_d) begin
            ifid_instr_d = NOP_INSTR;
        end else if (stall_d) begin
            ifid_instr_d = ifid_instr_q;
            ifid_pc_d    = ifid_pc_q;
            ifid_pc4_d   = ifid_pc4_q;
            ifid_valid_d = ifid_valid_q;
        end else if (deliver) begin
            ifid_instr_d = dlv_instr;
            ifid_pc_d    = dlv_pc;
            ifid_pc4_d   = pc_plus4(dlv_pc);
            ifid_valid_d = 1'b1;
        end
    end

    // State, PC, hold buffer and IF/ID registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q      <= ISSUE;
            pc_f_q       <= RESET_PC;
            hold_instr_q <= 32'd0;
            hold_pc_q    <= 32'd0;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc_q    <= 32'd0;
            ifid_pc4_q   <= 32'd0;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_f_q       <= pc_f_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    assign imem_req   = req & ~srst;
    assign imem_addr  = pc_f_q;
    assign instr_d    = ifid_instr_q;
    assign pc_d       = ifid_pc_q;
    assign pc_plus4_d = ifid_pc4_q;
    assign valid_d    = ifid_valid_q;

endmodule
